// File: rtl/led_time_counter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_time_counter_pkg                                                 |
// | Shared state encoding, widths and helpers for the LED time counter.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package led_time_counter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    PAUSED  = 2'd2,
    FULL    = 2'd3
  } state_t;

  localparam int LEVEL_W = 4;
  localparam int LAP_W   = 8;

  // Lap counter sticks at all-ones instead of wrapping.
  function automatic logic [LAP_W-1:0] satIncLap(input logic [LAP_W-1:0] v);
    return (v == {LAP_W{1'b1}}) ? v : v + LAP_W'(1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/led_step_prescaler.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_step_prescaler                                                   |
// | Terminal-count prescaler with enable and synchronous clear; emits a  |
// | one-cycle tick on the cycle that wraps the count back to zero.       |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_step_prescaler #(
  parameter int unsigned TICKS = 50000000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_enable,
  input  logic i_clear,
  output logic o_tick
);

  localparam int CNT_W = $clog2(TICKS);
  localparam logic [CNT_W-1:0] c_lastCount = CNT_W'(TICKS - 1);

  logic [CNT_W-1:0] r_count;
  logic             w_terminal;

  assign w_terminal = (r_count == c_lastCount);
  assign o_tick     = i_enable & ~i_clear & w_terminal;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_enable) begin
      r_count <= w_terminal ? '0 : r_count + CNT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/led_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | led_time_counter                                                     |
// | Elapsed-time fill level for the LED bar, with start/pause/clear      |
// | control, optional wrap-around and a saturating lap counter.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module led_time_counter
  import led_time_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_STEP = 50000000,
  parameter int unsigned MAX_LEVEL      = 10,
  parameter int unsigned WRAP           = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               pause,
  input  logic               clear,
  output logic [LEVEL_W-1:0] level,
  output logic               step_pulse,
  output logic               lap_pulse,
  output logic [LAP_W-1:0]   lap_count,
  output logic               running,
  output logic               full
);

  localparam logic [LEVEL_W-1:0] c_maxLevel = LEVEL_W'(MAX_LEVEL);
  localparam logic               c_wrap     = (WRAP != 0);

  state_t             r_state;
  logic [LEVEL_W-1:0] r_level;
  logic [LAP_W-1:0]   r_lapCount;
  logic               r_stepPulse;
  logic               r_lapPulse;
  logic               r_running;
  logic               r_full;
  logic               w_prescEnable;
  logic               w_prescClear;
  logic               w_step;

  // A pause or clear on a terminal-count cycle must swallow the step.
  assign w_prescEnable = (r_state == RUNNING) && !pause && !clear;
  assign w_prescClear  = clear || (r_state == IDLE) || (r_state == FULL);

  led_step_prescaler #(
    .TICKS (TICKS_PER_STEP)
  ) u_prescaler (
    .clk      (clk),
    .reset    (reset),
    .i_enable (w_prescEnable),
    .i_clear  (w_prescClear),
    .o_tick   (w_step)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= IDLE;
      r_level     <= '0;
      r_lapCount  <= '0;
      r_stepPulse <= 1'b0;
      r_lapPulse  <= 1'b0;
      r_running   <= 1'b0;
      r_full      <= 1'b0;
    end else begin
      r_stepPulse <= 1'b0;
      r_lapPulse  <= 1'b0;
      if (clear) begin
        r_state    <= IDLE;
        r_level    <= '0;
        r_lapCount <= '0;
        r_running  <= 1'b0;
        r_full     <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start && !pause) begin
              r_state   <= RUNNING;
              r_running <= 1'b1;
            end
          end
          RUNNING: begin
            if (pause) begin
              r_state   <= PAUSED;
              r_running <= 1'b0;
            end else if (w_step) begin
              if (r_level < c_maxLevel) begin
                r_level     <= r_level + LEVEL_W'(1);
                r_stepPulse <= 1'b1;
                if (!c_wrap && (r_level + LEVEL_W'(1) == c_maxLevel)) begin
                  r_state   <= FULL;
                  r_running <= 1'b0;
                  r_full    <= 1'b1;
                end
              end else if (c_wrap) begin
                r_level     <= '0;
                r_stepPulse <= 1'b1;
                r_lapPulse  <= 1'b1;
                r_lapCount  <= satIncLap(r_lapCount);
              end
            end
          end
          PAUSED: begin
            if (start && !pause) begin
              r_state   <= RUNNING;
              r_running <= 1'b1;
            end
          end
          FULL: begin
            r_state <= FULL;
          end
          default: begin
            r_state   <= IDLE;
            r_running <= 1'b0;
            r_full    <= 1'b0;
          end
        endcase
      end
    end
  end

  assign level      = r_level;
  assign step_pulse = r_stepPulse;
  assign lap_pulse  = c_wrap & r_lapPulse;
  assign lap_count  = r_lapCount;
  assign running    = r_running;
  assign full       = r_full;

endmodule
`default_nettype wire

// File: tb/tb_led_time_counter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_led_time_counter                                                  |
// | Three configurations checked every cycle against an elapsed-time     |
// | model, plus directed literal expectations.                           |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_led_time_counter;

  typedef struct {
    int mode;     // 0 idle, 1 running, 2 paused, 3 full
    int level;
    int elapsed;  // running cycles since the count was (re)started
    int laps;
    bit step;
    bit lap;
  } mdl_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       st [3];
  logic       pa [3];
  logic       cl [3];
  logic [3:0] lvl [3];
  logic       stp [3];
  logic       lapP [3];
  logic [7:0] laps [3];
  logic       run [3];
  logic       ful [3];

  int   nChecks = 0;
  int   nPass = 0;
  bit   checkEn = 1'b0;
  mdl_t m [3];

  always #5 clk = ~clk;

  led_time_counter #(.TICKS_PER_STEP(4), .MAX_LEVEL(10), .WRAP(0)) dutA (
    .clk(clk), .reset(reset), .start(st[0]), .pause(pa[0]), .clear(cl[0]),
    .level(lvl[0]), .step_pulse(stp[0]), .lap_pulse(lapP[0]), .lap_count(laps[0]),
    .running(run[0]), .full(ful[0]));

  led_time_counter #(.TICKS_PER_STEP(2), .MAX_LEVEL(10), .WRAP(1)) dutB (
    .clk(clk), .reset(reset), .start(st[1]), .pause(pa[1]), .clear(cl[1]),
    .level(lvl[1]), .step_pulse(stp[1]), .lap_pulse(lapP[1]), .lap_count(laps[1]),
    .running(run[1]), .full(ful[1]));

  led_time_counter #(.TICKS_PER_STEP(2), .MAX_LEVEL(1), .WRAP(1)) dutC (
    .clk(clk), .reset(reset), .start(st[2]), .pause(pa[2]), .clear(cl[2]),
    .level(lvl[2]), .step_pulse(stp[2]), .lap_pulse(lapP[2]), .lap_count(laps[2]),
    .running(run[2]), .full(ful[2]));

  function automatic int cfgT(int i);
    return (i == 0) ? 4 : 2;
  endfunction
  function automatic int cfgMax(int i);
    return (i == 2) ? 1 : 10;
  endfunction
  function automatic bit cfgWrap(int i);
    return (i != 0);
  endfunction

  function automatic mdl_t mdlInit();
    mdl_t n;
    n.mode = 0; n.level = 0; n.elapsed = 0; n.laps = 0; n.step = 0; n.lap = 0;
    return n;
  endfunction

  // One clock edge of the game timer, expressed as elapsed running time.
  function automatic mdl_t mdlStep(mdl_t cur, int T, int maxL, bit wrap,
                                   bit s, bit p, bit c);
    mdl_t n;
    n = cur;
    n.step = 0;
    n.lap  = 0;
    if (c) return mdlInit();
    case (cur.mode)
      0: if (s && !p) begin n.mode = 1; n.elapsed = 0; end
      1: begin
        if (p) begin
          n.mode = 2;
        end else begin
          n.elapsed = cur.elapsed + 1;
          if (n.elapsed % T == 0) begin
            n.step = 1;
            if (cur.level == maxL) begin
              n.level = 0;
              n.lap   = 1;
              n.laps  = (cur.laps < 255) ? cur.laps + 1 : 255;
            end else begin
              n.level = cur.level + 1;
              if (n.level == maxL && !wrap) n.mode = 3;
            end
          end
        end
      end
      2: if (s && !p) n.mode = 1;
      default: ;
    endcase
    return n;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    nChecks++;
    if (act === expv) nPass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
  endtask

  always @(posedge clk or posedge reset) begin
    for (int i = 0; i < 3; i++) begin
      if (reset) m[i] = mdlInit();
      else m[i] = mdlStep(m[i], cfgT(i), cfgMax(i), cfgWrap(i), st[i], pa[i], cl[i]);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("cycle_dut%0d{lvl,stp,lap,laps,run,full}", i),
            {16'd0, lvl[i], stp[i], lapP[i], laps[i], run[i], ful[i]},
            {16'd0, 4'(m[i].level), m[i].step, m[i].lap, 8'(m[i].laps),
             (m[i].mode == 1), (m[i].mode == 3)});
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin st[i] = 0; pa[i] = 0; cl[i] = 0; end
    cyc(2);
    reset = 1'b0;
    checkEn = 1'b1;
    cyc(1);
    chk("reset_level", 32'(lvl[0]), 32'd0);
    chk("reset_flags", {28'd0, stp[0], lapP[0], run[0], ful[0]}, 32'd0);
    chk("reset_laps", 32'(laps[0]), 32'd0);

    // Basic count to full
    st[0] = 1;
    cyc(1);
    chk("entry_running", 32'(run[0]), 32'd1);
    cyc(4);
    chk("first_step_level", 32'(lvl[0]), 32'd1);
    chk("first_step_pulse", 32'(stp[0]), 32'd1);
    cyc(36);
    chk("full_level", 32'(lvl[0]), 32'd10);
    chk("full_flags_run_full", {30'd0, run[0], ful[0]}, 32'd1);
    cyc(50);
    chk("full_hold_level", 32'(lvl[0]), 32'd10);

    // Pause and resume mid-interval
    cl[0] = 1; st[0] = 0;
    cyc(1);
    chk("clear_from_full", {24'd0, lvl[0], 2'b00, run[0], ful[0]}, 32'd0);
    cl[0] = 0; st[0] = 1;
    cyc(15);
    chk("pre_pause_level", 32'(lvl[0]), 32'd3);
    pa[0] = 1;
    cyc(7);
    chk("paused_level", 32'(lvl[0]), 32'd3);
    chk("paused_running", 32'(run[0]), 32'd0);
    pa[0] = 0;
    cyc(1);
    chk("resume_running", 32'(run[0]), 32'd1);
    cyc(1);
    chk("resume_no_step_yet", 32'(stp[0]), 32'd0);
    cyc(1);
    chk("resume_step_level", {27'd0, lvl[0], stp[0]}, {27'd0, 4'd4, 1'b1});

    // Clear beats start/pause and an imminent step
    cyc(4);
    chk("level5", 32'(lvl[0]), 32'd5);
    cyc(3);
    cl[0] = 1; st[0] = 1; pa[0] = 1;
    cyc(1);
    chk("clear_prio", {20'd0, lvl[0], stp[0], run[0], ful[0], laps[0], 1'b0}, 32'd0);
    cl[0] = 0; st[0] = 0; pa[0] = 0;

    // Asynchronous reset part-way through an interval
    st[0] = 1;
    cyc(27);
    chk("pre_reset_level", 32'(lvl[0]), 32'd6);
    #2 reset = 1'b1;
    #1;
    chk("async_reset_level", 32'(lvl[0]), 32'd0);
    chk("async_reset_flags", {28'd0, stp[0], lapP[0], run[0], ful[0]}, 32'd0);
    st[0] = 0;
    cyc(1);
    reset = 1'b0;
    st[0] = 1;
    cyc(4);
    chk("post_reset_no_step", {27'd0, lvl[0], stp[0]}, 32'd0);
    cyc(1);
    chk("post_reset_step", {27'd0, lvl[0], stp[0]}, {27'd0, 4'd1, 1'b1});
    pa[0] = 1;

    // Wrap with lap counting
    st[1] = 1;
    cyc(21);
    chk("wrap_level10", 32'(lvl[1]), 32'd10);
    cyc(2);
    chk("wrap_first_lap", {18'd0, lvl[1], stp[1], lapP[1], laps[1]},
        {18'd0, 4'd0, 1'b1, 1'b1, 8'd1});
    cyc(22);
    chk("wrap_second_lap", {18'd0, lvl[1], stp[1], lapP[1], laps[1]},
        {18'd0, 4'd0, 1'b1, 1'b1, 8'd2});

    // Start with pause from IDLE is ignored, then lap saturation
    st[2] = 1; pa[2] = 1;
    cyc(3);
    chk("illegal_combo", {27'd0, lvl[2], run[2]}, 32'd0);
    pa[2] = 0;
    cyc(1201);
    chk("lap_saturate", 32'(laps[2]), 32'd255);
    cyc(4);

    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/led_time_counter.md
Name: led_time_counter

Overview:
- Elapsed-time stage that drives the LED bar decoder directly. It produces a 4-bit fill level, 0..MAX_LEVEL, which the decoder turns into the 10-LED bar.
- A clock prescaler generates one "step" every TICKS_PER_STEP cycles while the game is running. Each step advances the level.
- Control inputs: start/pause/clear from game control logic.
- Status outputs: step, full and lap indications for scoring and difficulty logic.

Parameters:
- TICKS_PER_STEP, 50000000, clk cycles per level increment (1 s at 50 MHz); legal range 2..2^32-1.
- MAX_LEVEL, 10, highest level value; legal range 1..15.
- WRAP, 0, 0 = hold at MAX_LEVEL when reached; 1 = roll over to 0 and count a lap.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  level-sensitive; begin or resume counting.
- pause  in  1  level-sensitive; freeze counting.
- clear  in  1  synchronous; return to level 0 / IDLE.
- level  out  4  current fill level, 0..MAX_LEVEL; feeds the bar decoder's hexInput.
- step_pulse  out  1  one-cycle pulse, high in the same cycle the new level value appears.
- lap_pulse  out  1  one-cycle pulse on rollover (WRAP=1 only; otherwise constant 0).
- lap_count  out  8  rollovers since clear; saturates at 255.
- running  out  1  high in the RUNNING state.
- full  out  1  high in the FULL state.

Behaviour:
- Reset state: clk and reset as above; reset is asynchronous and active-high. Asserting reset immediately forces:
  - state = IDLE;
  - level = 0, prescaler = 0, lap_count = 0;
  - step_pulse, lap_pulse, running and full all = 0.
- Output timing: every output is registered. There is no combinational path from any input to any output.
- FSM states are IDLE, RUNNING, PAUSED and FULL. Input priority is clear > pause > start.
- clear:
  - Takes effect at the next clk edge from any state.
  - Forces IDLE and zeroes level, prescaler and lap_count.
  - Suppresses any step that would have occurred in the same cycle.
- IDLE:
  - start=1 with pause=0 moves to RUNNING.
  - The prescaler restarts from 0.
- RUNNING:
  - The prescaler increments each cycle.
  - When the prescaler equals TICKS_PER_STEP-1, it returns to 0 and a step occurs at that edge.
  - The first step therefore registers exactly TICKS_PER_STEP edges after the RUNNING entry edge.
  - pause=1 moves to PAUSED at the next edge. The prescaler value is retained, and no step occurs on that edge, even if the prescaler is at terminal count.
- PAUSED:
  - Level and prescaler are held.
  - start=1 with pause=0 moves back to RUNNING, and counting resumes from the held prescaler value.
  - start=1 with pause=1 stays in PAUSED.
- Step when level < MAX_LEVEL:
  - level increments by 1 and step_pulse=1 for that one cycle.
  - If the new level equals MAX_LEVEL and WRAP=0, the FSM moves to FULL on the same edge and full=1.
- Step when level == MAX_LEVEL and WRAP=1:
  - level becomes 0; step_pulse and lap_pulse are both 1 for that one cycle.
  - lap_count increments, saturating at 255.
  - The FSM stays in RUNNING.
- FULL (WRAP=0 only):
  - Level is held at MAX_LEVEL and the prescaler is held at 0.
  - start and pause are ignored; only clear or reset leaves this state.
- Widths:
  - The prescaler width is $clog2(TICKS_PER_STEP).
  - level never exceeds MAX_LEVEL, so the bar decoder's out-of-range default is never exercised.
- Reset mid-count: an asynchronous reset discards the prescaler phase. A later start always gives a full TICKS_PER_STEP interval before the first step.

Decomposition:
- Shared package holds:
  - FSM state typedef: IDLE=2'd0, RUNNING=2'd1, PAUSED=2'd2, FULL=2'd3;
  - LEVEL_W=4;
  - LAP_W=8.
- Sub-module led_step_prescaler:
  - Terminal-count counter with enable and synchronous clear inputs.
  - Outputs a one-cycle tick.
  - Reusable elsewhere for asteroid spawn timing.
- The FSM, level register and lap counter stay in the top module.

Test Plan:
- Basic count (TICKS_PER_STEP=4, WRAP=0): reset, then start held high → step_pulse every 4 cycles and level goes 1,2,…,10. full=1 in the cycle level becomes 10, running=0, and level stays 10 for 50 further cycles with start=1.
- Pause/resume (TICKS_PER_STEP=4): start, then pause for 7 cycles after level=3 and prescaler=2, then release with start=1 → level stays 3 during the pause; next step comes 2 cycles after RUNNING is re-entered; level=4.
- Wrap (WRAP=1, TICKS_PER_STEP=2): run 22 steps → level goes 10→0 with step_pulse and lap_pulse both high in the same cycle; lap_count=2 and level=0 after step 22. With TICKS_PER_STEP=2 and MAX_LEVEL=1, 600 steps → lap_count saturates at 255.
- Clear priority: clear, start and pause all asserted in the cycle the prescaler is at terminal count with level=5 → next cycle has level=0, state IDLE, step_pulse=0 and lap_count=0.
- Async reset: assert reset between clock edges while level=6 → level=0 and all flags=0 before the next edge. After release, start gives the first step exactly TICKS_PER_STEP edges later.
- Illegal combination: start=1 with pause=1 from IDLE → remains IDLE; level=0 and running=0.
